// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, NOP constant and fetch queue entry type
package cpu_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic              filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_entry_ring.sv
// rtl/fetch_entry_ring.sv - in-order fetch entry storage with alloc/fill/head pointers
module fetch_entry_ring
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          flush,
  input  logic          alloc,
  input  logic [AW-1:0] alloc_pc,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  input  logic          pop,
  output logic          head_filled,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_pc
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    alloc_ptr, fill_ptr, head_ptr;
  logic [AW-1:0]    pc_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= DW'(NOP);
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled_q  <= '0;
    end else begin
      if (alloc) begin
        pc_q[alloc_ptr]     <= alloc_pc;
        filled_q[alloc_ptr] <= 1'b0;
        alloc_ptr           <= alloc_ptr + PW'(1);
      end
      // fill_ptr only ever points at an allocated, unfilled entry, so it never aliases head on a pop
      if (fill) begin
        data_q[fill_ptr]   <= fill_data;
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
    end
  end

  assign head_filled = filled_q[head_ptr];
  assign head_data   = data_q[head_ptr];
  assign head_pc     = pc_q[head_ptr];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: memory request/grant, credit and drop
// accounting, and an in-order PC-tagged instruction queue feeding decode
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  output logic              PCAdvance,
  input  logic              Redirect,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemGnt,
  input  logic              MemRValid,
  input  logic [DATA_W-1:0] MemRData,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  input  logic              InstrReady
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [CW-1:0] alloc_cnt, pend_cnt, drop_cnt;
  logic [CW:0]   credit_used;
  logic          grant, resp_drop, resp_fill, pop;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^PC[1:0];
  assign MemAddr        = {PC[ADDR_W-1:2], 2'b00};

  // Entries awaiting a discarded response still hold a credit until it returns
  assign credit_used = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign MemReq      = Reset & ~Redirect & (credit_used < CAP);
  assign grant       = MemReq & MemGnt;
  assign PCAdvance   = grant;

  assign resp_drop = MemRValid & (drop_cnt != '0);
  assign resp_fill = MemRValid & (drop_cnt == '0) & (pend_cnt != '0);
  assign pop       = InstrValid & InstrReady & ~Redirect;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (Redirect) begin
      // a response landing this cycle, dropped or not, is one fewer to discard later
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_cnt + pend_cnt - CW'(resp_drop | resp_fill);
    end else begin
      alloc_cnt <= alloc_cnt + CW'(grant) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(grant) - CW'(resp_fill);
      drop_cnt  <= drop_cnt - CW'(resp_drop);
    end
  end

  fetch_entry_ring #(
    .DEPTH(DEPTH),
    .AW   (ADDR_W),
    .DW   (DATA_W)
  ) u_ring (
    .Clk        (Clk),
    .Reset      (Reset),
    .flush      (Redirect),
    .alloc      (grant),
    .alloc_pc   (PC),
    .fill       (resp_fill),
    .fill_data  (MemRData),
    .pop        (pop),
    .head_filled(InstrValid),
    .head_data  (Instr),
    .head_pc    (InstrPC)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue with a
// latency-configurable in-order memory model and a PC register model
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic              PCAdvance;
  logic              Redirect = 1'b0;
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemGnt = 1'b0;
  logic              MemRValid = 1'b0;
  logic [DATA_W-1:0] MemRData = '0;
  logic              InstrValid;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic              InstrReady = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PC        (PC),
    .PCAdvance (PCAdvance),
    .Redirect  (Redirect),
    .MemReq    (MemReq),
    .MemAddr   (MemAddr),
    .MemGnt    (MemGnt),
    .MemRValid (MemRValid),
    .MemRData  (MemRData),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .InstrReady(InstrReady)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  logic [ADDR_W-1:0] pc_next = '0;
  logic [ADDR_W-1:0] redir_target = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } rd_t;
  rd_t          rd_q[$];
  fetch_entry_t pop_log[$];

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe grants, pops and next-PC away from the active edge
  always @(negedge Clk) begin
    if (Reset) begin
      if (MemReq && MemGnt) rd_q.push_back('{MemAddr, cyc + lat});
      if (InstrValid && InstrReady && !Redirect)
        pop_log.push_back('{pc: InstrPC, data: Instr, filled: 1'b1});
      pc_next = Redirect ? redir_target : (PCAdvance ? PC + 32'd4 : PC);
    end else begin
      pc_next = '0;
    end
  end

  always @(posedge Clk) begin
    #1;
    cyc++;
    PC = Reset ? pc_next : '0;
    MemRValid = 1'b0;
    MemRData  = '0;
    if (!Reset) begin
      rd_q.delete();
    end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      MemRValid = 1'b1;
      MemRData  = memf(rd_q[0].addr);
      void'(rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  task automatic restart(input int l, input logic gnt, input logic rdy);
    Reset = 1'b0;
    Redirect = 1'b0;
    MemGnt = gnt;
    InstrReady = rdy;
    lat = l;
    tick();
    tick();
    pop_log.delete();
    Reset = 1'b1;
  endtask

  task automatic expect_log(input string tag, input logic [ADDR_W-1:0] first, input int n);
    check($sformatf("%s_log_len", tag), 64'(pop_log.size() >= n), 64'(1));
    for (int i = 0; i < n; i++) begin
      if (i < pop_log.size()) begin
        check($sformatf("%s_pc%0d", tag, i), 64'(pop_log[i].pc), 64'(first + ADDR_W'(4 * i)));
        check($sformatf("%s_data%0d", tag, i), 64'(pop_log[i].data), 64'(memf(first + ADDR_W'(4 * i))));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    tick();
    at_neg();
    check("rst_memreq", 64'(MemReq), 64'(0));
    check("rst_pcadv", 64'(PCAdvance), 64'(0));
    check("rst_valid", 64'(InstrValid), 64'(0));
    check("rst_instr", 64'(Instr), 64'(0));
    check("rst_instrpc", 64'(InstrPC), 64'(0));

    // streaming: grant every cycle, 1-cycle latency, decode always ready
    restart(1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      check($sformatf("t1_pcadv%0d", k), 64'(PCAdvance), 64'(1));
      check($sformatf("t1_addr%0d", k), 64'(MemAddr), 64'(4 * k));
      if (k >= 2) begin
        check($sformatf("t1_valid%0d", k), 64'(InstrValid), 64'(1));
        check($sformatf("t1_ipc%0d", k), 64'(InstrPC), 64'(4 * (k - 2)));
        check($sformatf("t1_instr%0d", k), 64'(Instr), 64'(memf(ADDR_W'(4 * (k - 2)))));
      end
      tick();
    end

    // stalled decode: exactly DEPTH grants, head held, then drain and resume
    restart(1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      check($sformatf("t2_memreq%0d", k), 64'(MemReq), 64'(k < 4));
      check($sformatf("t2_pcadv%0d", k), 64'(PCAdvance), 64'(k < 4));
      if (k >= 2) begin
        check($sformatf("t2_valid%0d", k), 64'(InstrValid), 64'(1));
        check($sformatf("t2_ipc%0d", k), 64'(InstrPC), 64'(0));
      end
      tick();
    end
    InstrReady = 1'b1;
    at_neg();
    check("t2_full_memreq", 64'(MemReq), 64'(0));
    tick();
    at_neg();
    check("t2_resume_memreq", 64'(MemReq), 64'(1));
    check("t2_resume_addr", 64'(MemAddr), 64'(16));
    repeat (8) tick();
    expect_log("t2", 32'h0, 8);

    // 3-cycle latency, redirect with two reads in flight
    restart(3, 1'b1, 1'b1);
    tick();
    tick();
    Redirect = 1'b1;
    redir_target = 32'h40;
    at_neg();
    check("t3_redir_memreq", 64'(MemReq), 64'(0));
    tick();
    Redirect = 1'b0;
    at_neg();
    check("t3_target_addr", 64'(MemAddr), 64'(32'h40));
    check("t3_target_memreq", 64'(MemReq), 64'(1));
    repeat (14) tick();
    expect_log("t3", 32'h40, 4);

    // redirect coinciding with a response and a pop request
    restart(1, 1'b1, 1'b1);
    tick();
    tick();
    Redirect = 1'b1;
    redir_target = 32'h80;
    at_neg();
    check("t4_redir_memreq", 64'(MemReq), 64'(0));
    check("t4_redir_valid", 64'(InstrValid), 64'(1));
    check("t4_redir_ipc", 64'(InstrPC), 64'(0));
    tick();
    Redirect = 1'b0;
    at_neg();
    check("t4_flushed_valid", 64'(InstrValid), 64'(0));
    repeat (8) tick();
    expect_log("t4", 32'h80, 4);

    // back-to-back redirects
    restart(2, 1'b1, 1'b1);
    tick();
    tick();
    Redirect = 1'b1;
    redir_target = 32'h100;
    at_neg();
    check("t5_r1_memreq", 64'(MemReq), 64'(0));
    tick();
    redir_target = 32'h200;
    at_neg();
    check("t5_r2_memreq", 64'(MemReq), 64'(0));
    tick();
    Redirect = 1'b0;
    at_neg();
    check("t5_target_addr", 64'(MemAddr), 64'(32'h200));
    repeat (8) tick();
    expect_log("t5", 32'h200, 3);

    // asynchronous reset with a full queue and two reads in flight
    restart(3, 1'b1, 1'b0);
    repeat (5) tick();
    at_neg();
    check("t6_full_memreq", 64'(MemReq), 64'(0));
    check("t6_full_valid", 64'(InstrValid), 64'(1));
    check("t6_full_instr", 64'(Instr), 64'(memf(32'h0)));
    #2;
    Reset = 1'b0;
    #1;
    check("t6_async_memreq", 64'(MemReq), 64'(0));
    check("t6_async_pcadv", 64'(PCAdvance), 64'(0));
    check("t6_async_valid", 64'(InstrValid), 64'(0));
    check("t6_async_instr", 64'(Instr), 64'(0));
    check("t6_async_ipc", 64'(InstrPC), 64'(0));
    lat = 1;
    InstrReady = 1'b1;
    tick();
    tick();
    pop_log.delete();
    Reset = 1'b1;
    at_neg();
    check("t6_restart_memreq", 64'(MemReq), 64'(1));
    check("t6_restart_addr", 64'(MemAddr), 64'(0));
    repeat (6) tick();
    expect_log("t6", 32'h0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC, issues word reads to instruction memory over a request/grant interface, and tells next-PC logic when to advance.
- Buffers returned instructions, each tagged with its PC, in an in-order queue that feeds decode through a valid/ready handshake.
- Flushes everything on a branch/jump redirect and discards read data still in flight.

Parameters:
- DEPTH, 4: queue entries; also the maximum number of outstanding plus buffered fetches (power of 2, ≥2).
- ADDR_W, 32: PC / memory address width.
- DATA_W, 32: instruction width.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous active-low reset (0 = reset).
- PC  input  ADDR_W  current fetch address from the program counter.
- PCAdvance  output  1  fetch of PC accepted this cycle; next-PC logic loads PC+4.
- Redirect  input  1  taken branch/jump; flush the queue. PC carries the new target from the next cycle.
- MemReq  output  1  read request to instruction memory.
- MemAddr  output  ADDR_W  read address = {PC[ADDR_W-1:2],2'b00}.
- MemGnt  input  1  memory accepted the request this cycle.
- MemRValid  input  1  read data valid. Responses return in request order, at least 1 cycle after grant.
- MemRData  input  DATA_W  read data.
- InstrValid  output  1  head entry holds a filled instruction.
- Instr  output  DATA_W  head instruction.
- InstrPC  output  ADDR_W  PC of the head instruction.
- InstrReady  input  1  decode consumes the head when InstrValid & InstrReady.

Behaviour:
- Reset asserted (async):
  - Queue empty; all pointers and counters 0; drop_cnt 0.
  - MemReq, PCAdvance and InstrValid are 0; Instr and InstrPC are 0.
- Queue: ring of DEPTH entries {pc, data, filled}, with three pointers:
  - alloc_ptr: entry allocated at grant.
  - fill_ptr: entry written by the next response.
  - head_ptr: entry output to decode.
- alloc_cnt counts allocated entries (filled or not). drop_cnt counts in-flight responses that must be discarded.
- MemReq = Reset & ~Redirect & (alloc_cnt + drop_cnt < DEPTH). MemReq is combinational and may drop without a grant; memory must tolerate this.
- Grant (MemReq & MemGnt):
  - Allocates the entry at alloc_ptr with pc = PC and filled = 0.
  - PCAdvance = MemReq & MemGnt, same cycle.
  - Sustained throughput is 1 fetch per cycle.
- Response (MemRValid):
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: write data to the entry at fill_ptr, set filled, advance fill_ptr.
  - MemRValid arriving while no entry is awaiting data and drop_cnt = 0 is a protocol error; the bench flags it and the design ignores it.
- Output:
  - InstrValid = head entry filled (registered).
  - Response-to-InstrValid latency is 1 cycle.
  - Instr and InstrPC are held stable while InstrValid & ~InstrReady.
- Pop: InstrValid & InstrReady clears filled, advances head_ptr and decrements alloc_cnt.
- Same-cycle grant, response and pop are all legal. alloc_cnt += grant − pop.
- Redirect (highest priority):
  - Same cycle: MemReq = 0, so no grant.
  - Next edge: all entries invalid, pointers reset to 0, alloc_cnt = 0.
  - drop_cnt ← (unfilled allocated entries) + drop_cnt − (1 if a response arrived this cycle).
  - Any pop requested in the Redirect cycle is ignored; InstrValid is 0 the next cycle.
- Back-to-back Redirect: each cycle recomputes drop_cnt the same way, with no loss or double count.
- Full: alloc_cnt + drop_cnt = DEPTH means MemReq = 0 and PC holds (no PCAdvance).
- Empty: InstrValid = 0.
- Pointers wrap modulo DEPTH. Counters are $clog2(DEPTH)+1 bits.
- Reset mid-operation: immediate return to the reset state. Outstanding memory responses after reset are the memory's responsibility (memory resets on the same Reset).

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W and DATA_W constants.
  - NOP instruction constant 32'h0000_0000.
  - Typedef fetch_entry_t {pc, data, filled}.
- One natural sub-module, fetch_entry_ring: the DEPTH-entry storage with alloc/fill/head pointers and per-entry filled bits.
- The parent holds the credit and drop counters and the handshake logic.

Test Plan:
- Reset release, PC = 0, memory grants every cycle, 1-cycle latency, InstrReady = 1:
  - PCAdvance each cycle; MemAddr 0, 4, 8, …
  - Instr/InstrPC pairs (mem[0],0), (mem[4],4), … at 1 per cycle, starting 2 cycles after the first grant.
- InstrReady = 0 with continuous grants:
  - Exactly 4 grants, then MemReq = 0 and PCAdvance = 0.
  - Head holds InstrPC = 0 stable.
  - InstrReady = 1 drains 4 entries in order, and fetching resumes.
- 3-cycle memory latency: Redirect to PC = 0x40 with 2 reads in flight:
  - The 2 stale responses are dropped.
  - The first InstrValid carries InstrPC = 0x40.
  - No stale instruction is ever output.
- Redirect in the same cycle as a response and InstrReady = 1: no pop, the response is dropped, and drop_cnt is correct. Verified by the next valid instr being the target.
- Redirect on 2 consecutive cycles, then normal fetch: only instructions from the second target appear.
- Reset asserted while the queue is full with 2 reads in flight:
  - Outputs go to 0 asynchronously.
  - After release, fetch restarts from PC = 0 with an empty queue.
